// File: rtl/pc_link_pkg.sv
// pc_link_pkg -- shared encodings for the PC serial link.
//   Game FSM state codes, ASCII bytes sent to the PC, the TX FSM state enum,
//   and small helpers for decoding the one-hot mole position.
package pc_link_pkg;

  localparam logic [1:0] GAME_IDLE    = 2'd0;
  localparam logic [1:0] GAME_RUNNING = 2'd1;
  localparam logic [1:0] GAME_FINISH  = 2'd2;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_R    = 8'h52;
  localparam logic [7:0] ASCII_H    = 8'h48;
  localparam logic [7:0] ASCII_S    = 8'h53;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_BUSY = 2'd1,
    S_WAIT_DONE = 2'd2
  } tx_state_e;

  function automatic logic is_onehot5(input logic [4:0] v);
    return (v != 5'd0) && ((v & (v - 5'd1)) == 5'd0);
  endfunction

  function automatic logic [2:0] onehot_index5(input logic [4:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 5; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// byte_fifo -- synchronous FIFO with show-ahead read data.
//   clock, reset : clock and synchronous active-high reset
//   push/wr_data : write request; accepted when not full, or when full with a
//                  simultaneous pop (the pop frees the slot first)
//   pop/rd_data  : rd_data always presents the head entry; pop removes it
//   full/empty   : occupancy flags
//   level        : current occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module byte_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign full    = (level_q == FULL_LVL);
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rd_data = mem_q[rd_ptr_q];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/pc_tx_scheduler.sv
// pc_tx_scheduler -- turns game events into bytes queued for uart_tx.
//   clock, reset   : clock and synchronous active-high reset
//   mole_position  : one-hot active mole; a new mole while game_active sends '0'+index
//   game_active    : game running flag
//   fsm_state      : game FSM state; entering FINISH sends 'R' once
//   tx_busy        : uart_tx busy flag
//   rx_data/rx_ready (PC_ECHO_EN only): received byte, echoed back to the PC
//   tx_start       : one-cycle start strobe to uart_tx
//   tx_data        : byte being sent, stable from tx_start until back in S_IDLE
//   fifo_level     : queue occupancy
//   drop_count     : saturating count of bytes lost to a full queue
// Build option: define PC_ECHO_EN to add the rx ports and the echo source.
//
// state       | meaning
// S_IDLE      | waiting for a queued byte and tx_busy low
// S_WAIT_BUSY | strobe issued, waiting up to WAIT_BUSY_MAX cycles for tx_busy
// S_WAIT_DONE | uart_tx is shifting the byte, waiting for tx_busy to fall
module pc_tx_scheduler
  import pc_link_pkg::*;
#(
  parameter int FIFO_DEPTH    = 8,
  parameter int WAIT_BUSY_MAX = 15
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [4:0]                    mole_position,
  input  logic                          game_active,
  input  logic [1:0]                    fsm_state,
  input  logic                          tx_busy,
`ifdef PC_ECHO_EN
  input  logic [7:0]                    rx_data,
  input  logic                          rx_ready,
`endif
  output logic                          tx_start,
  output logic [7:0]                    tx_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    drop_count
);

  localparam int TW = (WAIT_BUSY_MAX > 1) ? $clog2(WAIT_BUSY_MAX) : 1;
  localparam logic [TW-1:0] TIMER_LOAD = TW'(WAIT_BUSY_MAX - 1);

  tx_state_e   state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [7:0]  drop_q, drop_d;
  logic [4:0]  last_q, last_d;
  logic        sent_q, sent_d;
  logic        r_pend_q, r_pend_d;
  logic        mole_pend_q, mole_pend_d;
  logic [7:0]  mole_byte_q, mole_byte_d;
`ifdef PC_ECHO_EN
  logic        echo_pend_q, echo_pend_d;
  logic [7:0]  echo_byte_q, echo_byte_d;
`endif

  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]  fifo_wr_data, fifo_rd_data;

  byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (fifo_push),
    .wr_data (fifo_wr_data),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Event detection and queue-write arbitration. Slots are cleared by the
  // write before new detections are applied, so a fresh event in the same
  // cycle overwrites rather than being lost.
  always_comb begin
    r_pend_d     = r_pend_q;
    mole_pend_d  = mole_pend_q;
    mole_byte_d  = mole_byte_q;
    last_d       = last_q;
    sent_d       = sent_q;
    drop_d       = drop_q;
    fifo_push    = 1'b0;
    fifo_wr_data = 8'h00;
`ifdef PC_ECHO_EN
    echo_pend_d  = echo_pend_q;
    echo_byte_d  = echo_byte_q;
`endif

    if (r_pend_q) begin
      fifo_push    = 1'b1;
      fifo_wr_data = ASCII_R;
      r_pend_d     = 1'b0;
    end else if (mole_pend_q) begin
      fifo_push    = 1'b1;
      fifo_wr_data = mole_byte_q;
      mole_pend_d  = 1'b0;
    end
`ifdef PC_ECHO_EN
    else if (echo_pend_q) begin
      fifo_push    = 1'b1;
      fifo_wr_data = echo_byte_q;
      echo_pend_d  = 1'b0;
    end
`endif

    // A full queue with no pop this cycle swallows the byte.
    if (fifo_push && fifo_full && !fifo_pop && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end

    if (mole_position == 5'd0) begin
      last_d = 5'd0;
    end else if (game_active && is_onehot5(mole_position) && (mole_position != last_q)) begin
      mole_pend_d = 1'b1;
      mole_byte_d = ASCII_ZERO + {5'd0, onehot_index5(mole_position)};
      last_d      = mole_position;
    end

    if (fsm_state == GAME_IDLE) begin
      sent_d = 1'b0;
      last_d = 5'd0;
    end else if ((fsm_state == GAME_FINISH) && !sent_q) begin
      r_pend_d = 1'b1;
      sent_d   = 1'b1;
    end

`ifdef PC_ECHO_EN
    if (rx_ready) begin
      echo_pend_d = 1'b1;
      echo_byte_d = rx_data;
    end
`endif
  end

  // TX FSM. tx_start is combinational so a byte written to an empty queue
  // goes out the very next cycle; reset gates it so nothing leaves while
  // reset is held.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    tx_data_d = tx_data_q;
    tx_start  = 1'b0;
    fifo_pop  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty && !tx_busy && !reset) begin
          tx_start  = 1'b1;
          fifo_pop  = 1'b1;
          tx_data_d = fifo_rd_data;
          timer_d   = TIMER_LOAD;
          state_d   = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        if (tx_busy)              state_d = S_WAIT_DONE;
        else if (timer_q == '0)   state_d = S_IDLE;
        else                      timer_d = timer_q - 1'b1;
      end
      S_WAIT_DONE: begin
        if (!tx_busy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign tx_data    = tx_start ? fifo_rd_data : tx_data_q;
  assign drop_count = drop_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      tx_data_q   <= 8'h00;
      drop_q      <= 8'h00;
      last_q      <= 5'd0;
      sent_q      <= 1'b0;
      r_pend_q    <= 1'b0;
      mole_pend_q <= 1'b0;
      mole_byte_q <= 8'h00;
`ifdef PC_ECHO_EN
      echo_pend_q <= 1'b0;
      echo_byte_q <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      tx_data_q   <= tx_data_d;
      drop_q      <= drop_d;
      last_q      <= last_d;
      sent_q      <= sent_d;
      r_pend_q    <= r_pend_d;
      mole_pend_q <= mole_pend_d;
      mole_byte_q <= mole_byte_d;
`ifdef PC_ECHO_EN
      echo_pend_q <= echo_pend_d;
      echo_byte_q <= echo_byte_d;
`endif
    end
  end

endmodule

// File: doc/pc_tx_scheduler.md
PC_TX_SCHEDULER -- requirements
Module: pc_tx_scheduler

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning the byte queue depth; legal values are powers of two from 2 to 64.
REQ-002 SHALL have parameter WAIT_BUSY_MAX, default 15, meaning the cycles to wait for tx_busy to rise after tx_start before abandoning the byte.
REQ-003 clock  input  1  system clock; one clock domain; reset is synchronous and active-high.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 mole_position  input  5  one-hot active mole from the mole generator.
REQ-006 game_active  input  1  high while the game FSM is in the running state.
REQ-007 fsm_state  input  2  game FSM state: 0=IDLE, 1=RUNNING, 2=FINISH.
REQ-008 tx_busy  input  1  uart_tx busy flag.
REQ-009 tx_start  output  1  single-cycle start strobe to uart_tx.
REQ-010 tx_data  output  8  byte to transmit; held stable from tx_start until the return to S_IDLE.
REQ-011 fifo_level  output  $clog2(FIFO_DEPTH)+1  current queue occupancy.
REQ-012 drop_count  output  8  saturating count of bytes lost to a full queue.
REQ-013 rx_data  input  8  received byte (PC_ECHO_EN builds only).
REQ-014 rx_ready  input  1  one-cycle received-byte strobe (PC_ECHO_EN builds only).

Function
REQ-015 Mole event SHALL fire when game_active=1, mole_position is one-hot, and mole_position differs from the last-reported register; it enqueues ASCII '0'+index (0x30..0x34) and updates the last-reported register.
REQ-016 mole_position=0 SHALL clear the last-reported register without enqueueing; multi-hot values SHALL be ignored.
REQ-017 Game-over event SHALL fire once when fsm_state becomes 2 and the sent flag is clear; it enqueues 'R' (0x52) and sets the sent flag.
REQ-018 fsm_state=0 SHALL clear the sent flag and the last-reported register.
REQ-019 Each event source SHALL own a one-entry pending slot; an event sets or overwrites its slot in the cycle it is detected.
REQ-020 The queue SHALL accept one write per cycle, in priority 'R' > mole > echo; the chosen slot clears on that write and the other slots wait.
REQ-021 A write attempted while fifo_level=FIFO_DEPTH SHALL discard the byte, clear its slot, and increment drop_count, which saturates at 255.
REQ-022 A simultaneous push and pop on a full queue SHALL succeed, because the pop frees space first; level is unchanged.
REQ-023 The TX FSM SHALL have states S_IDLE, S_WAIT_BUSY and S_WAIT_DONE.
REQ-024 S_IDLE: when the queue is non-empty and tx_busy=0, the FSM SHALL pop, load tx_data, pulse tx_start for one cycle, and go to S_WAIT_BUSY.
REQ-025 S_WAIT_BUSY: the FSM SHALL go to S_WAIT_DONE when tx_busy=1, and return to S_IDLE after WAIT_BUSY_MAX cycles without tx_busy.
REQ-026 S_WAIT_DONE: the FSM SHALL return to S_IDLE when tx_busy=0.
REQ-027 Latency SHALL be: event detected at cycle N, written to the queue at N+1, tx_start at N+2, given an idle FSM and an empty queue.
REQ-028 tx_start SHALL never be asserted in two consecutive cycles, nor while tx_busy=1.

Reset
REQ-029 Reset SHALL set tx_start=0, tx_data=0, fifo_level=0, drop_count=0, FSM=S_IDLE, all pending slots and flags cleared, and last-reported=0.
REQ-030 Reset asserted mid-transfer SHALL abandon the byte in flight and the queue contents; tx_start SHALL stay 0 until at least one cycle after reset is released.

Configuration
REQ-031 With macro PC_ECHO_EN defined, rx_ready=1 SHALL set the echo slot with rx_data, so every received byte is queued back to the PC.
REQ-032 Without PC_ECHO_EN, the rx_data and rx_ready ports SHALL be absent and no echo logic SHALL be synthesised.

Structure
REQ-033 Package pc_link_pkg SHALL hold the FSM state encodings (IDLE/RUNNING/FINISH), the ASCII codes ('0', 'R', 'H', 'S') and the TX FSM state enum.
REQ-034 The queue SHALL be a sub-module named byte_fifo, parameterised by depth and width, with push, pop, full, empty and level ports.

Verification
REQ-035 game_active=1 and mole_position 00001->00100, with tx_busy modelled 10 cycles per byte -> bytes 0x30 then 0x32 are sent, and tx_start pulses are at least 12 cycles apart.
REQ-036 fsm_state 1->2, held for 100 cycles -> exactly one 0x52; fsm_state 2->0->1->2 -> a second 0x52.
REQ-037 In a single cycle: mole change to 01000 plus entry to FINISH -> queue order 0x52 then 0x33.
REQ-038 tx_busy held at 1 while 12 mole changes occur with FIFO_DEPTH=8 -> fifo_level=8 and drop_count=4; after release, exactly 8 bytes are sent.
REQ-039 tx_busy never rises after tx_start -> return to S_IDLE after 15 cycles, and the next byte is sent.
REQ-040 PC_ECHO_EN build, rx_ready strobed with 0x48 -> 0x48 sent at N+2; reset pulsed during S_WAIT_DONE -> all outputs at their reset values the next cycle.
